// File: rtl/result_uart_tx.sv
// Result UART transmitter: buffers strobed 9-bit filter samples in a FIFO and
// sends each one as a two-byte 8N1 frame, {4'hA,3'b000,sample[8]} then sample[7:0].
module result_uart_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 9
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              ovf_q;

  logic [DATA_W-1:0] sample_q;
  logic [7:0]        shift_q;
  logic [7:0]        cur_byte;
  logic [2:0]        bit_idx;
  logic              byte_sel;
  logic [CNT_W-1:0]  baud_cnt;
  logic              tx_q;

  logic push, pop, bit_done;
  logic load_byte, shift_en, set_byte1, tx_next;

  assign bit_done = (baud_cnt == CNT_LAST);
  assign cur_byte = byte_sel ? sample_q[7:0] : {4'hA, 3'b000, sample_q[8]};

  // A full FIFO still accepts a sample when the FSM pops on the same edge.
  assign push = sample_valid && ((level != LVL_FULL) || pop);

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_byte  = 1'b0;
    shift_en   = 1'b0;
    set_byte1  = 1'b0;
    tx_next    = tx_q;
    unique case (state)
      S_IDLE: begin
        tx_next = 1'b1;
        if (level != '0) begin
          pop        = 1'b1;
          state_next = S_START;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          load_byte  = 1'b1;
          state_next = S_DATA;
          tx_next    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
            tx_next    = 1'b1;
          end else begin
            shift_en = 1'b1;
            tx_next  = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (!byte_sel) begin
            set_byte1  = 1'b1;
            state_next = S_START;
            tx_next    = 1'b0;
          end else if (level != '0) begin
            pop        = 1'b1;
            state_next = S_START;
            tx_next    = 1'b0;
          end else begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      sample_q <= '0;
      shift_q  <= '0;
    end else begin
      state <= state_next;
      tx_q  <= tx_next;
      // Counter restarts on every bit boundary and is held at zero while idle.
      if (state == S_IDLE || bit_done) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + CNT_W'(1);
      if (pop) begin
        sample_q <= mem[rd_ptr];
        byte_sel <= 1'b0;
      end else if (set_byte1) begin
        byte_sel <= 1'b1;
      end
      if (load_byte) begin
        shift_q <= cur_byte;
        bit_idx <= '0;
      end else if (shift_en) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // NOTE: the storage array is not reset; pointers and level define its valid contents.
  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (sample_valid && !push) ovf_q <= 1'b1;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state != S_IDLE);
  assign overflow   = ovf_q;
  assign fifo_level = level;

endmodule
